// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the EX stage and the data RAM port.
// It accepts one load or store request per handshake and drives a word-aligned RAM
// access. mem_valid is held for LATENCY cycles. The load word is then extracted and
// sign- or zero-extended, and the result is returned on a valid/ready response
// channel. Illegal and misaligned requests are answered with resp_err and make no
// RAM access.
//
// Ports:
//   clock, reset               clock; asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_wen, req_funct3        1 = store; access size/signedness (B,H,W,BU,HU)
//   req_addr, req_wdata        byte address; store data (LSBs significant)
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       extended load data (0 for stores/errors); error flag
//   mem_valid, mem_wen         RAM request active; single-cycle write strobe
//   mem_waddr, mem_raddr       word-aligned address
//   mem_wdata, mem_wmask       lane-replicated store data; byte-lane mask
//   mem_rdata                  RAM read word
module lsu_mem_ctrl #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic        wen_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        first_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        bad_req;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  // Check legality of the incoming request. The check is done before the request
  // is latched, so a bad request never reaches the RAM port.
  always_comb begin
    bad_req = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
      bad_req = 1'b1;
    if (req_wen && req_funct3[2])
      bad_req = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      bad_req = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      bad_req = 1'b1;
  end

  // Store lane mask and replicated data, built from the latched request.
  always_comb begin
    st_mask = 4'hF;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: move the addressed byte or half down to bit 0, then extend it.
  always_comb begin
    ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_raddr  = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = bad_req ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_waddr = {addr_q[31:2], 2'b00};
        mem_raddr = {addr_q[31:2], 2'b00};
        if (wen_q) begin
          mem_wmask = st_mask;
          mem_wdata = st_data;
          // Write only on the first cycle: the RAM model is combinational, so the
          // strobe must not repeat while the access is being held for the latency.
          mem_wen   = first_q;
        end
        if (cnt_q == 4'd0)
          state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_rdata = (state_q == RESP) ? rdata_q : '0;
    resp_err   = (state_q == RESP) ? err_q : 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q   <= req_wen;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad_req;
        rdata_q <= '0;
        cnt_q   <= CNT_INIT;
        first_q <= 1'b1;
      end
      if (state_q == ACCESS) begin
        first_q <= 1'b0;
        if (cnt_q == 4'd0)
          rdata_q <= wen_q ? '0 : ld_ext;
        else
          cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  localparam int unsigned LAT = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [3:0]  mem_wmask;

  lsu_mem_ctrl #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] mdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: tracks each accepted transaction and compares against the queue head.
  bit          inflight = 0, seen_resp = 0, prev_hold = 0, chk_ready_next = 0;
  int          lat = 0, vcnt = 0, wcnt = 0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      inflight = 0; prev_hold = 0; chk_ready_next = 0;
      if (resp_valid) check("resp_in_reset", {31'h0, resp_valid}, 32'h0);
    end else begin
      if (inflight) begin
        lat++;
        check("req_ready_busy", {31'h0, req_ready}, 32'h0);
        if (mem_valid) begin
          vcnt++;
          check("mem_waddr", mem_waddr, q[0].addr);
          check("mem_raddr", mem_raddr, q[0].addr);
          if (mem_wen) begin
            wcnt++;
            check("mem_wmask", {28'h0, mem_wmask}, {28'h0, q[0].mask});
            check("mem_wdata", mem_wdata, q[0].mdata);
          end else if (!q[0].wen) begin
            check("load_wmask", {28'h0, mem_wmask}, 32'h0);
          end
        end
        if (resp_valid) begin
          if (!seen_resp) begin
            seen_resp = 1;
            check("resp_latency", lat, q[0].err ? 1 : LAT + 1);
            check("mem_valid_cycles", vcnt, q[0].err ? 0 : LAT);
            check("write_pulses", wcnt, (q[0].wen && !q[0].err) ? 1 : 0);
          end
          if (prev_hold) begin
            check("hold_rdata", resp_rdata, hold_rdata);
            check("hold_err", {31'h0, resp_err}, {31'h0, hold_err});
          end
          if (resp_ready) begin
            check("resp_rdata", resp_rdata, q[0].rdata);
            check("resp_err", {31'h0, resp_err}, {31'h0, q[0].err});
            void'(q.pop_front());
            inflight = 0; prev_hold = 0; chk_ready_next = 1;
          end else begin
            prev_hold = 1; hold_rdata = resp_rdata; hold_err = resp_err;
          end
        end
      end else begin
        if (chk_ready_next) begin
          check("req_ready_after", {31'h0, req_ready}, 32'h1);
          chk_ready_next = 0;
        end
        if (resp_valid || mem_valid)
          check("spurious_activity", {30'h0, resp_valid, mem_valid}, 32'h0);
      end
      if (req_valid && req_ready) begin
        if (q.size() == 0) check("accept_without_expect", 32'h1, 32'h0);
        else begin
          inflight = 1; seen_resp = 0; prev_hold = 0;
          lat = 0; vcnt = 0; wcnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mrd,
                       input logic [3:0] emask, input logic [31:0] emdata,
                       input logic [31:0] erdata, input logic eerr);
    exp_t e;
    bit ok = 0;
    e.wen = wen; e.addr = {addr[31:2], 2'b00}; e.mask = emask;
    e.mdata = emdata; e.rdata = erdata; e.err = eerr;
    @(posedge clock); #1;
    q.push_back(e);
    mem_rdata = mrd;
    req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 32'h1, 32'h0);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input int hold);
    bit ok = 0;
    resp_ready = (hold == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (resp_valid) begin ok = 1; break; end
    end
    if (!ok) check("resp_timeout", 32'h1, 32'h0);
    if (hold > 0) begin
      repeat (hold) @(posedge clock);
      #1 resp_ready = 1'b1;
      @(negedge clock);
    end
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] mrd,
                      input logic [3:0] emask, input logic [31:0] emdata,
                      input logic [31:0] erdata, input logic eerr, input int hold);
    issue(wen, f3, addr, wdata, mrd, emask, emdata, erdata, eerr);
    finish_resp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 0; req_wen = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0; mem_rdata = 0;
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    #11 reset_n = 1'b1;

    //   wen f3      addr          wdata         mem_rdata     mask     mdata         rdata         err hold
    xact(1, 3'b000, 32'h80000002, 32'h12345678, 32'h0,        4'b0100, 32'h78787878, 32'h0,        0, 0);
    xact(0, 3'b000, 32'h80000003, 32'h0,        32'h80FF0011, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0);
    xact(0, 3'b100, 32'h80000003, 32'h0,        32'h80FF0011, 4'b0000, 32'h0,        32'h00000080, 0, 0);
    xact(0, 3'b001, 32'h80000002, 32'h0,        32'h80010000, 4'b0000, 32'h0,        32'hFFFF8001, 0, 0);
    xact(0, 3'b101, 32'h80000002, 32'h0,        32'h80010000, 4'b0000, 32'h0,        32'h00008001, 0, 0);
    xact(0, 3'b010, 32'h80000001, 32'h0,        32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0,        1, 0);
    xact(0, 3'b010, 32'h80000010, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 5);
    xact(1, 3'b001, 32'h80000002, 32'hAAAABEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0);
    xact(1, 3'b010, 32'h80000004, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        0, 2);
    xact(1, 3'b100, 32'h80000000, 32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    xact(0, 3'b011, 32'h80000000, 32'h0,        32'h12345678, 4'b0000, 32'h0,        32'h0,        1, 0);
    xact(1, 3'b001, 32'h80000001, 32'h0000FFFF, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 3);
    xact(0, 3'b000, 32'h80000000, 32'h0,        32'h0000007F, 4'b0000, 32'h0,        32'h0000007F, 0, 0);
    xact(0, 3'b101, 32'h80000000, 32'h0,        32'h1234FFFE, 4'b0000, 32'h0,        32'h0000FFFE, 0, 0);

    // Reset asserted while a store is in ACCESS: outputs must clear without a clock.
    issue(1, 3'b010, 32'h80000008, 32'h11223344, 32'h0, 4'b1111, 32'h11223344, 32'h0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("mid_rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    check("mid_rst_wmask", {28'h0, mem_wmask}, 32'h0);
    check("mid_rst_waddr", mem_waddr, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    check("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    xact(0, 3'b010, 32'h80000020, 32'h0, 32'h01234567, 4'b0000, 32'h0, 32'h01234567, 0, 0);

    repeat (4) @(posedge clock);
    #1 check("queue_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the EX stage and the DPI-backed data RAM port.
- Accepts one load or store request per handshake. Generates the word-aligned address, byte mask and replicated write data. Extracts and sign- or zero-extends load data.
- Holds the RAM port valid for a programmable latency, then returns the result on a valid/ready response channel.

Parameters:
- LATENCY, 1, cycles mem_valid is held before mem_rdata is sampled (legal range 1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (LSBs significant)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal access
- mem_valid  out  1  RAM request active
- mem_wen  out  1  RAM write enable
- mem_waddr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_wmask  out  4  byte-lane mask
- mem_raddr  out  32  {addr[31:2],2'b00}
- mem_rdata  in  32  RAM read word

Behaviour:
- Reset (reset=0, async) forces all of the following:
  - state to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_valid=0, mem_wen=0, mem_wmask=0, addresses and mem_wdata=0.
  - Any in-flight operation is dropped with no response.
- States:
  - IDLE: req_ready=1. On req_valid, latch req fields.
    - If illegal or misaligned: go to RESP with err=1, no memory activity.
    - Otherwise: go to ACCESS and load counter = LATENCY-1.
  - ACCESS: mem_valid=1 and addresses driven from the latched addr.
    - mem_wen=1 only on the first ACCESS cycle (exactly one write pulse per store).
    - Counter decrements each cycle. When it reads 0, capture the extended mem_rdata (loads) into resp_rdata and go to RESP. ACCESS therefore lasts exactly LATENCY cycles.
  - RESP: resp_valid=1, mem_valid=0, resp outputs stable. On resp_ready, go to IDLE.
- Minimum latency: request accepted at edge N → resp_valid at edge N+LATENCY+1. Error path: resp_valid at edge N+1.
- req_ready=0 in ACCESS and RESP; a new request cannot be accepted in the same cycle a response completes.
- Legality:
  - funct3 011, 110 and 111 are illegal.
  - Stores with funct3 100 or 101 are illegal.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- Store mask and data:
  - B: mask = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - H: mask = 4'b0011<<addr[1:0], data = {2{wdata[15:0]}}.
  - W: mask = 4'hF, data = wdata.
- Loads: mem_wen=0, mem_wmask=0. Shift mem_rdata right by 8*addr[1:0], then:
  - B: sign-extend bit 7.
  - BU: zero-extend 8 bits.
  - H: sign-extend bit 15.
  - HU: zero-extend 16 bits.
  - W: unchanged.
- Outside ACCESS, mem_valid=0 and mem_wen=0 so the combinational RAM model sees no spurious writes.

Test Plan:
- Store byte: SB addr 0x80000002, wdata 0x12345678 → one cycle with mem_wen=1, wmask=4'b0100, mem_wdata=0x78787878, mem_waddr=0x80000000; then resp_valid with rdata=0, err=0.
- Byte loads: LB addr 0x80000003, mem_rdata 0x80FF0011 → resp_rdata 0xFFFFFF80. Same access as LBU → 0x00000080.
- Half loads: LH addr 0x80000002, mem_rdata 0x80010000 → 0xFFFF8001. Same access as LHU → 0x00008001.
- Misaligned word: LW addr 0x80000001 → resp_valid with err=1 one cycle after acceptance; mem_valid stays 0 throughout.
- Latency and backpressure: LATENCY=3, LW, resp_ready held 0 for 5 cycles →
  - mem_valid high exactly 3 cycles.
  - resp_valid and resp_rdata stable until resp_ready.
  - req_ready=0 throughout, returning to 1 the cycle after the handshake.
- Reset mid-operation: assert reset during ACCESS of an SW → all outputs 0 immediately (asynchronous), no resp_valid. After release, a new LW completes normally.
